// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with carry-in and a start/done handshake.
// The operands are added one bit per clock, LSB first. A registered carry links
// each bit to the next. Each bit uses a full adder made from two half_adder
// cells and an OR of their carries.
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : request, sampled only in IDLE
//   A, B, Cin      : operands and carry-in, captured on the accepting edge
//   busy           : high while bits are being processed
//   done           : one-cycle pulse when Sum/Cout update
//   Sum, Cout      : registered (A+B+Cin) mod 2^WIDTH and its carry-out

// half_adder: combinational single-bit half adder.
//   a, b    : input bits
//   sum_c   : a ^ b
//   carry_c : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum_c,
  output logic carry_c
);
  assign sum_c   = a ^ b;
  assign carry_c = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_a_q, shift_a_d;
  logic [WIDTH-1:0]   shift_b_q, shift_b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  // Full-add slice on the current LSBs and the carry flop
  logic half_sum_c, half_carry_c;
  logic bit_sum_c, prop_carry_c;
  logic bit_carry_c;

  half_adder u_ha_ab (
    .a       (shift_a_q[0]),
    .b       (shift_b_q[0]),
    .sum_c   (half_sum_c),
    .carry_c (half_carry_c)
  );

  half_adder u_ha_cin (
    .a       (half_sum_c),
    .b       (carry_q),
    .sum_c   (bit_sum_c),
    .carry_c (prop_carry_c)
  );

  assign bit_carry_c = half_carry_c | prop_carry_c;

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    cout_d    = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_a_d = A;
          shift_b_d = B;
          carry_d   = Cin;
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB
        acc_d     = {bit_sum_c, acc_q[WIDTH-1:1]};
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        carry_d   = bit_carry_c;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = acc_d;
          cout_d  = bit_carry_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8,
// with a cycle-timeline reference model compared on every falling edge.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an operation is a timeline of cycles since acceptance.
  // The result is plain integer addition; done lasts one cycle, then a one-cycle gap.
  int               m_phase;
  logic             m_busy, m_done, m_cout, m_cin;
  logic [WIDTH-1:0] m_sum, m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_cin   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     <= A;
        m_b     <= B;
        m_cin   <= Cin;
        m_busy  <= 1'b1;
        m_phase <= 1;
      end
    end else if (m_phase < int'(WIDTH)) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == int'(WIDTH)) begin
      {m_cout, m_sum} <= (WIDTH+1)'(m_a) + (WIDTH+1)'(m_b) + (WIDTH+1)'(m_cin);
      m_done  <= 1'b1;
      m_busy  <= 1'b0;
      m_phase <= m_phase + 1;
    end else begin
      m_done  <= 1'b0;
      m_phase <= 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("sum", 32'(Sum), 32'(m_sum));
    check("cout", 32'(Cout), 32'(m_cout));
    check("busy_and_done", 32'(busy & done), 32'(0));
  end

  // One start pulse; operands scrambled right after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] es, input logic ec, input string tag);
    int busy_cnt;
    int done_cyc;
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
    busy_cnt = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      if (busy) busy_cnt++;
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(WIDTH + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, " Sum"}, 32'(Sum), 32'(es));
    check({tag, " Cout"}, 32'(Cout), 32'(ec));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int               n_done;
    int               d_cyc [2];
    logic [WIDTH-1:0] d_sum [2];
    logic             d_cout [2];
    logic [WIDTH-1:0] ra, rb, es;
    logic             rc, ec;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset Sum", 32'(Sum), 32'(0));
    check("reset Cout", 32'(Cout), 32'(0));
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "5A+3C");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF+FF+1");
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "00+00+1");

    // start and new operands during RUN are ignored
    @(negedge clk);
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 3) begin start = 1'b1; A = 8'h11; B = 8'h22; end
      if (cyc == 6) start = 1'b0;
      if (done) n_done++;
      @(negedge clk);
    end
    check("ignore done_count", 32'(n_done), 32'(1));
    check("ignore Sum", 32'(Sum), 32'(8'h30));
    check("ignore Cout", 32'(Cout), 32'(0));

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    A = 8'h5A; B = 8'h3C; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async busy", 32'(busy), 32'(0));
    check("async done", 32'(done), 32'(0));
    check("async Sum", 32'(Sum), 32'(0));
    check("async Cout", 32'(Cout), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("post_reset done_count", 32'(n_done), 32'(0));
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "after_reset");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'h80; B = 8'h80;
    n_done = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (cyc == 11) start = 1'b0;
      if (done) begin
        if (n_done < 2) begin
          d_cyc[n_done]  = cyc;
          d_sum[n_done]  = Sum;
          d_cout[n_done] = Cout;
        end
        n_done++;
      end
      @(negedge clk);
    end
    check("held done_count", 32'(n_done), 32'(2));
    if (n_done >= 2) begin
      check("held first done_cycle", 32'(d_cyc[0]), 32'(9));
      check("held first Sum", 32'(d_sum[0]), 32'(8'h02));
      check("held first Cout", 32'(d_cout[0]), 32'(0));
      check("held second done_cycle", 32'(d_cyc[1]), 32'(19));
      check("held second Sum", 32'(d_sum[1]), 32'(8'h00));
      check("held second Cout", 32'(d_cout[1]), 32'(1));
    end

    // random operands with idle gaps of varying length
    for (int i = 0; i < 150; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      {ec, es} = (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc);
      run_op(ra, rb, rc, es, ec, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
